collision_detector: RTL and testbench

COLLISION_DETECTOR -- requirements
Module: collision_detector

---
 rtl/collision_detector.sv | 127 ++++++++++++
 tb/tb_collision_detector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/collision_detector.sv
// Player/obstacle collision detector with frame-based reporting and cooldown.
// A player/obstacle overlap anywhere in a frame is reported as one registered
// collision pulse one clk after the startOfFrame that ends that frame. After a
// report, overlaps are ignored for COOLDOWN_FRAMES frames. hit_count saturates at 255.
// Optional feature: define COLLISION_BORDER_EN to enable player/border reporting
// on collision_border; otherwise that output is tied low.
module collision_detector #(
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       drawing_request_player,
    input  logic       drawing_request_obstacle,
    input  logic       drawing_request_border,
    output logic       collision,
    output logic       collision_border,
    output logic [7:0] hit_count
);

    localparam logic [1:0] ARMED       = 2'd0;
    localparam logic [1:0] HIT_PENDING = 2'd1;
    localparam logic [1:0] COOLDOWN    = 2'd2;

    localparam logic [7:0] CoolLoad = 8'(COOLDOWN_FRAMES);

    logic [1:0] state_q, state_d;
    logic [7:0] cool_cnt_q, cool_cnt_d;
    logic [7:0] hit_cnt_q, hit_cnt_d;
    logic       collision_q, collision_d;
    logic       overlap;

    assign overlap = drawing_request_player & drawing_request_obstacle;

    // Next-state logic: latch a hit, report it at end of frame, then hold off.
    always_comb begin
        state_d     = state_q;
        cool_cnt_d  = cool_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        collision_d = 1'b0;
        case (state_q)
            ARMED: begin
                // An overlap coinciding with startOfFrame belongs to the next frame.
                if (overlap) begin
                    state_d = HIT_PENDING;
                end
            end
            HIT_PENDING: begin
                if (startOfFrame) begin
                    collision_d = 1'b1;
                    cool_cnt_d  = CoolLoad;
                    hit_cnt_d   = (hit_cnt_q == 8'hFF) ? hit_cnt_q : hit_cnt_q + 8'd1;
                    state_d     = (CoolLoad == 8'd0) ? ARMED : COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (startOfFrame) begin
                    // Guard against underflow; a count of 1 ends the cooldown.
                    cool_cnt_d = (cool_cnt_q == 8'd0) ? 8'd0 : cool_cnt_q - 8'd1;
                    if (cool_cnt_q <= 8'd1) begin
                        state_d = ARMED;
                    end
                end
            end
            default: begin
                state_d    = ARMED;
                cool_cnt_d = 8'd0;
            end
        endcase
    end

    // State registers; reset discards any pending hit and remaining cooldown.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ARMED;
            cool_cnt_q  <= 8'd0;
            hit_cnt_q   <= 8'd0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cool_cnt_q  <= cool_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;
    assign hit_count = hit_cnt_q;

`ifdef COLLISION_BORDER_EN
    logic border_flag_q, border_flag_d;
    logic border_pulse_q, border_pulse_d;
    logic border_overlap;

    assign border_overlap = drawing_request_player & drawing_request_border;

    // Border flag: startOfFrame reports and clears it; an overlap on that same
    // clk re-arms it for the following frame.
    always_comb begin
        border_pulse_d = 1'b0;
        border_flag_d  = border_flag_q | border_overlap;
        if (startOfFrame) begin
            border_pulse_d = border_flag_q;
            border_flag_d  = border_overlap;
        end
    end

    // Border registers, independent of the hit FSM and cooldown.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            border_flag_q  <= 1'b0;
            border_pulse_q <= 1'b0;
        end else begin
            border_flag_q  <= border_flag_d;
            border_pulse_q <= border_pulse_d;
        end
    end

    assign collision_border = border_pulse_q;
`else
    logic unused_border;

    assign unused_border    = drawing_request_border;
    assign collision_border = 1'b0;
`endif

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: two instances (cooldown 2 and 0)
// share one stimulus stream; a frame-level reference model predicts outputs.
module tb_collision_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetN;
    logic       startOfFrame;
    logic       dr_player;
    logic       dr_obstacle;
    logic       dr_border;
    logic       col_a, cb_a, col_b, cb_b;
    logic [7:0] hc_a, hc_b;

    collision_detector #(.COOLDOWN_FRAMES(2)) dut_a (
        .clk                     (clk),
        .resetN                  (resetN),
        .startOfFrame            (startOfFrame),
        .drawing_request_player  (dr_player),
        .drawing_request_obstacle(dr_obstacle),
        .drawing_request_border  (dr_border),
        .collision               (col_a),
        .collision_border        (cb_a),
        .hit_count               (hc_a)
    );

    collision_detector #(.COOLDOWN_FRAMES(0)) dut_b (
        .clk                     (clk),
        .resetN                  (resetN),
        .startOfFrame            (startOfFrame),
        .drawing_request_player  (dr_player),
        .drawing_request_obstacle(dr_obstacle),
        .drawing_request_border  (dr_border),
        .collision               (col_b),
        .collision_border        (cb_b),
        .hit_count               (hc_b)
    );

    typedef struct packed {
        logic       col;
        logic       cb;
        logic [7:0] hc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: a pending hit, frames of cooldown left, hits, border flag.
    bit m_pend[2];
    int m_cool[2];
    int m_hits[2];
    bit m_bflag[2];
    int m_cd[2] = '{2, 0};

    task automatic model_edge(input int k, input logic sof, input logic p, input logic o,
                              input logic b, input logic rn, output exp_t e);
        bit armed;
        e = '0;
        if (!rn) begin
            m_pend[k]  = 0;
            m_cool[k]  = 0;
            m_hits[k]  = 0;
            m_bflag[k] = 0;
        end else begin
            armed = !m_pend[k] && (m_cool[k] == 0);
            if (m_pend[k] && sof) begin
                e.col     = 1'b1;
                m_hits[k] = (m_hits[k] < 255) ? m_hits[k] + 1 : 255;
                m_pend[k] = 0;
                m_cool[k] = m_cd[k];
            end else if (m_cool[k] > 0 && sof) begin
                m_cool[k] = m_cool[k] - 1;
            end else if (armed && p && o) begin
                m_pend[k] = 1;
            end
            e.hc = 8'(m_hits[k]);
`ifdef COLLISION_BORDER_EN
            e.cb       = sof && m_bflag[k];
            m_bflag[k] = sof ? (p && b) : (m_bflag[k] || (p && b));
`else
            e.cb = 1'b0;
`endif
        end
    endtask

    // Drive one clk of inputs at the negedge and queue the predicted post-edge outputs.
    task automatic step(input logic sof, input logic p, input logic o, input logic b,
                        input logic rn);
        exp_t ea, eb;
        startOfFrame = sof;
        dr_player    = p;
        dr_obstacle  = o;
        dr_border    = b;
        resetN       = rn;
        model_edge(0, sof, p, o, b, rn, ea);
        model_edge(1, sof, p, o, b, rn, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(negedge clk);
    endtask

    // One frame: overlap in [of, of+on), player/border in [bf, bf+bn), SOF on last clk.
    task automatic frame(input int len, input int of, input int on, input int bf, input int bn);
        for (int i = 0; i < len; i++) begin
            logic ov, bo;
            ov = (i >= of) && (i < of + on);
            bo = (i >= bf) && (i < bf + bn);
            step(i == len - 1, ov || bo, ov, bo, 1'b1);
        end
    endtask

    task automatic check(input string name, input exp_t act, input exp_t req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual col=%b cb=%b hc=%0d required col=%b cb=%b hc=%0d",
                     name, $time, act.col, act.cb, act.hc, req.col, req.cb, req.hc);
        end
    endtask

    // Monitor: sample just after each rising edge, compare against queued predictions.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) check("dut_cd2", {col_a, cb_a, hc_a}, q_a.pop_front());
        if (q_b.size() > 0) check("dut_cd0", {col_b, cb_b, hc_b}, q_b.pop_front());
    end

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        dr_player    = 1'b0;
        dr_obstacle  = 1'b0;
        dr_border    = 1'b0;
        @(negedge clk);

        // Reset state.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Overlap 5 clks in frame 0, then frames 1..3 with overlap (cooldown of 2).
        frame(10, 2, 5, 0, 0);
        frame(10, 1, 3, 0, 0);
        frame(10, 1, 3, 0, 0);
        frame(10, 1, 3, 0, 0);
        frame(10, 0, 0, 0, 0);
        frame(10, 0, 0, 0, 0);
        frame(10, 0, 0, 0, 0);

        // Overlap only on the SOF clk: reported one frame later.
        frame(10, 9, 1, 0, 0);
        frame(10, 0, 0, 0, 0);
        frame(10, 0, 0, 0, 0);

        // Cooldown in dut_cd2 while player/border overlaps.
        frame(8, 1, 2, 0, 0);
        frame(8, 0, 0, 2, 2);
        frame(8, 0, 0, 0, 0);

        // Overlap then reset 3 clks before SOF: nothing reported, counts cleared.
        for (int i = 0; i < 10; i++) begin
            logic ov;
            ov = (i == 2) || (i == 3);
            step(i == 9, ov, ov, 1'b0, !(i >= 5 && i <= 7));
        end
        frame(10, 0, 0, 0, 0);
        frame(10, 0, 0, 0, 0);

        // 300 consecutive frames with overlap: dut_cd0 saturates at 255.
        for (int f = 0; f < 300; f++) begin
            int len, pos;
            len = 4 + int'($urandom_range(8));
            pos = int'($urandom_range(len - 2));
            frame(len, pos, 1 + int'($urandom_range(1)), int'($urandom_range(len - 1)),
                  int'($urandom_range(1)));
        end

        // Fully random clk-level traffic with occasional reset.
        for (int f = 0; f < 80; f++) begin
            int len;
            len = 3 + int'($urandom_range(9));
            for (int i = 0; i < len; i++) begin
                step(i == len - 1, ($urandom % 3) == 0, ($urandom % 3) == 0,
                     ($urandom % 4) == 0, ($urandom % 150) != 0);
            end
        end

        @(posedge clk);
        #2;
        n_tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d/%0d required=0/0", q_a.size(), q_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
